// File: rtl/fdivsqrt_intpostproc_pipe.sv
// fdivsqrt_intpostproc_pipe: two-stage integer postprocessor for the
// divide/square-root unit. Stage 1 resolves the carry-save residual into
// its sign, zero flag, shifted remainder and corrected quotient. Stage 2
// picks quotient or remainder, normalizes it, applies the sign and special
// cases, and sign-extends W-mode results.
`timescale 1ns/1ps
module fdivsqrt_intpostproc_pipe #(
    parameter  int XLEN = 64,
    parameter  int LOGR = 1,
    localparam int RW   = XLEN + 4,
    localparam int SHW  = $clog2(XLEN + 4)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [RW-1:0]     WS,
    input  logic [RW-1:0]     WC,
    input  logic [RW-1:0]     D,
    input  logic [XLEN:0]     U,
    input  logic [XLEN:0]     UM,
    input  logic [XLEN-1:0]   A,
    input  logic              RemOp,
    input  logic              As,
    input  logic              Bs,
    input  logic              W64,
    input  logic              BZero,
    input  logic              ALTB,
    input  logic              SignedOvf,
    input  logic [SHW-1:0]    NormShift,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [XLEN-1:0]   Result,
    output logic              Sticky
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. InReady depends only on pipeline state and OutReady,
    // never on InValid. Once OutValid is high, Result and Sticky stay stable
    // until OutReady takes them. flush outranks any transfer into stage 1.

    // Stage 1 state
    logic              s1_valid;
    logic              s1_negsum;
    logic              s1_sumzero;
    logic [RW-1:0]     s1_w;
    logic [RW-1:0]     s1_wd;
    logic [RW-1:0]     s1_q;
    logic [XLEN-1:0]   s1_a;
    logic              s1_remop;
    logic              s1_as;
    logic              s1_bs;
    logic              s1_w64;
    logic              s1_bzero;
    logic              s1_altb;
    logic              s1_ovf;
    logic [SHW-1:0]    s1_ns;

    // Stage 2 state
    logic              s2_valid;
    logic [XLEN-1:0]   s2_result;
    logic              s2_sticky;

    // Flow control
    logic              s1_adv;
    logic              accept;

    assign s1_adv   = s1_valid & (~s2_valid | OutReady);
    assign InReady  = ~s1_valid | s1_adv;
    assign accept   = InValid & InReady & ~flush;
    assign OutValid = s2_valid;
    assign Result   = s2_result;
    assign Sticky   = s2_sticky;

    // Stage 1 combinational: resolve the residual and the quotient candidate
    logic [RW-1:0] sum_c;
    logic          negsum_c;
    logic [RW-1:0] w_c;
    logic [RW-1:0] wd_c;
    logic [RW-1:0] q_c;

    assign sum_c    = WS + WC;
    assign negsum_c = sum_c[RW-1];
    assign w_c      = $signed(sum_c) >>> LOGR;
    assign wd_c     = w_c + D;
    assign q_c      = negsum_c ? RW'(UM) : RW'(U);

    // Stage 2 combinational: select, normalize, sign-correct, substitute
    logic [RW-1:0]   rem_c;
    logic [RW-1:0]   pre_c;
    logic [RW-1:0]   shifted_c;
    logic            neg_c;
    logic [XLEN-1:0] val_c;
    logic [XLEN-1:0] base_c;
    logic [XLEN-1:0] result_c;
    logic            sticky_c;

    assign rem_c     = s1_negsum ? s1_wd : s1_w;
    assign pre_c     = s1_remop ? rem_c : s1_q;
    assign shifted_c = pre_c >> s1_ns;
    assign neg_c     = s1_as ^ (s1_bs & ~s1_remop);
    assign val_c     = XLEN'(neg_c ? (-shifted_c) : shifted_c);
    assign sticky_c  = ~s1_sumzero & ~(s1_bzero | s1_altb | s1_ovf);

    // Special-case substitution, highest priority first
    always_comb begin
        base_c = val_c;
        if (s1_bzero)
            base_c = s1_remop ? s1_a : '1;
        else if (s1_altb)
            base_c = s1_remop ? s1_a : '0;
        else if (s1_ovf)
            base_c = s1_remop ? '0 : s1_a;
    end

    // W-mode results on a 64-bit datapath are sign-extended from bit 31
    generate
        if (XLEN == 64) begin : g_w64
            assign result_c = s1_w64 ? {{32{base_c[31]}}, base_c[31:0]} : base_c;
        end else begin : g_nw64
            assign result_c = base_c;
        end
    endgenerate

    // Stage 1 valid: set on accept, cleared when it drains or on flush
    always_ff @(posedge clk) begin
        if (!reset)
            s1_valid <= 1'b0;
        else if (flush)
            s1_valid <= 1'b0;
        else if (accept)
            s1_valid <= 1'b1;
        else if (s1_adv)
            s1_valid <= 1'b0;
    end

    // Stage 1 data: captured on accept, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_negsum  <= negsum_c;
            s1_sumzero <= (sum_c == '0);
            s1_w       <= w_c;
            s1_wd      <= wd_c;
            s1_q       <= q_c;
            s1_a       <= A;
            s1_remop   <= RemOp;
            s1_as      <= As;
            s1_bs      <= Bs;
            s1_w64     <= W64;
            s1_bzero   <= BZero;
            s1_altb    <= ALTB;
            s1_ovf     <= SignedOvf;
            s1_ns      <= NormShift;
        end
    end

    // Stage 2: load on advance, drop valid once the consumer takes it
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_sticky <= 1'b0;
        end else begin
            if (flush)
                s2_valid <= 1'b0;
            else if (s1_adv)
                s2_valid <= 1'b1;
            else if (s2_valid & OutReady)
                s2_valid <= 1'b0;
            if (s1_adv & ~flush) begin
                s2_result <= result_c;
                s2_sticky <= sticky_c;
            end
        end
    end

endmodule

// File: tb/tb_fdivsqrt_intpostproc_pipe.sv
// Directed bench for fdivsqrt_intpostproc_pipe: a 32-bit instance covers the
// arithmetic, special cases and flow control, a 64-bit instance covers
// W-mode sign extension.
`timescale 1ns/1ps
module tb_fdivsqrt_intpostproc_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic flush;

  // ---------------- 32-bit instance ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [35:0] ws, wc, d;
  logic [32:0] u, um;
  logic [31:0] a;
  logic        rem_op, a_s, b_s, w64, b_zero, a_ltb, signed_ovf;
  logic [5:0]  norm_shift;
  logic [31:0] result;
  logic        sticky;

  fdivsqrt_intpostproc_pipe #(.XLEN(32), .LOGR(1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .InValid(in_valid), .InReady(in_ready),
    .WS(ws), .WC(wc), .D(d), .U(u), .UM(um), .A(a),
    .RemOp(rem_op), .As(a_s), .Bs(b_s), .W64(w64),
    .BZero(b_zero), .ALTB(a_ltb), .SignedOvf(signed_ovf),
    .NormShift(norm_shift),
    .OutValid(out_valid), .OutReady(out_ready),
    .Result(result), .Sticky(sticky)
  );

  // ---------------- 64-bit instance ----------------
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [67:0] h_ws, h_wc, h_d;
  logic [64:0] h_u, h_um;
  logic [63:0] h_a;
  logic        h_w64;
  logic [6:0]  h_norm_shift;
  logic [63:0] h_result;
  logic        h_sticky;

  fdivsqrt_intpostproc_pipe #(.XLEN(64), .LOGR(1)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .InValid(h_in_valid), .InReady(h_in_ready),
    .WS(h_ws), .WC(h_wc), .D(h_d), .U(h_u), .UM(h_um), .A(h_a),
    .RemOp(1'b0), .As(1'b0), .Bs(1'b0), .W64(h_w64),
    .BZero(1'b0), .ALTB(1'b0), .SignedOvf(1'b0),
    .NormShift(h_norm_shift),
    .OutValid(h_out_valid), .OutReady(h_out_ready),
    .Result(h_result), .Sticky(h_sticky)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [35:0] m2 = 36'hF_FFFF_FFFE;   // -2 at 36 bits

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // flags = {BZero, ALTB, SignedOvf}
  task automatic set_op(input logic [35:0] ws_i, input logic [35:0] wc_i,
                        input logic [35:0] d_i, input logic [32:0] u_i,
                        input logic [32:0] um_i, input logic [31:0] a_i,
                        input logic remop_i, input logic as_i, input logic bs_i,
                        input logic [2:0] flags, input logic [5:0] ns_i);
    ws = ws_i; wc = wc_i; d = d_i; u = u_i; um = um_i; a = a_i;
    rem_op = remop_i; a_s = as_i; b_s = bs_i; w64 = 1'b0;
    {b_zero, a_ltb, signed_ovf} = flags;
    norm_shift = ns_i;
  endtask

  // plain positive-residual quotient op whose result is u_i, sticky 1
  task automatic set_q(input logic [32:0] u_i);
    set_op(36'd1, 36'd0, 36'd2, u_i, u_i - 33'd1, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);
  endtask

  // one op through an unstalled pipe; called at posedge+1
  task automatic run32(input string tag, input logic [31:0] exp_res, input logic exp_st);
    check({tag, "_inready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_result"}, {32'd0, result}, {32'd0, exp_res});
    check({tag, "_sticky"}, {63'd0, sticky}, {63'd0, exp_st});
    @(posedge clk); #1;
    check({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run64(input string tag, input logic w64_i, input logic [63:0] exp_res);
    h_u = 65'h0_8000_0000;
    h_um = 65'h0_7FFF_FFFF;
    h_w64 = w64_i;
    h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'd0, h_out_valid}, 64'd1);
    check({tag, "_result"}, h_result, exp_res);
    check({tag, "_sticky"}, {63'd0, h_sticky}, 64'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    set_q(33'd0);
    h_in_valid = 1'b0; h_out_ready = 1'b1;
    h_ws = '0; h_wc = '0; h_d = '0; h_u = '0; h_um = '0; h_a = '0;
    h_w64 = 1'b0; h_norm_shift = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outvalid", {63'd0, out_valid}, 64'd0);
    check("rst_inready", {63'd0, in_ready}, 64'd1);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_sticky", {63'd0, sticky}, 64'd0);
    check("rst_result64", h_result, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // arithmetic
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);
    run32("q_pos", 32'd3, 1'b1);
    set_op(m2, 36'd0, 36'd2, 33'd4, 33'd3, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);
    run32("q_negres", 32'd3, 1'b1);
    set_op(m2, 36'd0, 36'd2, 33'd4, 33'd3, 32'd0, 1'b1, 1'b0, 1'b0, 3'b000, 6'd0);
    run32("rem_negres", 32'd1, 1'b1);
    set_op(m2, 36'd0, 36'd2, 33'd4, 33'd3, 32'd0, 1'b0, 1'b1, 1'b0, 3'b000, 6'd0);
    run32("q_as", 32'hFFFF_FFFD, 1'b1);
    set_op(m2, 36'd0, 36'd2, 33'd4, 33'd3, 32'd0, 1'b0, 1'b0, 1'b1, 3'b000, 6'd0);
    run32("q_bs", 32'hFFFF_FFFD, 1'b1);
    set_op(m2, 36'd0, 36'd2, 33'd4, 33'd3, 32'd0, 1'b1, 1'b0, 1'b1, 3'b000, 6'd0);
    run32("rem_bs", 32'd1, 1'b1);
    // WS+WC wraps to zero: no sticky, positive path, normalization shift
    set_op(36'd2, m2, 36'd2, 33'h30, 33'h2F, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd4);
    run32("q_shift", 32'd3, 1'b0);

    // special cases
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h1234, 1'b0, 1'b0, 1'b0, 3'b100, 6'd0);
    run32("bzero_q", 32'hFFFF_FFFF, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h1234, 1'b1, 1'b0, 1'b0, 3'b100, 6'd0);
    run32("bzero_r", 32'h1234, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h1234, 1'b0, 1'b0, 1'b0, 3'b010, 6'd0);
    run32("altb_q", 32'd0, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h1234, 1'b1, 1'b0, 1'b0, 3'b010, 6'd0);
    run32("altb_r", 32'h1234, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'b001, 6'd0);
    run32("ovf_q", 32'h8000_0000, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 3'b001, 6'd0);
    run32("ovf_r", 32'd0, 1'b0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'h1234, 1'b0, 1'b0, 1'b0, 3'b110, 6'd0);
    run32("prio_bz_altb", 32'hFFFF_FFFF, 1'b0);

    // W-mode on the 64-bit datapath
    run64("w64_on", 1'b1, 64'hFFFF_FFFF_8000_0000);
    run64("w64_off", 1'b0, 64'h0000_0000_8000_0000);

    // back-pressure: two ops fill the pipe, the third is held off
    out_ready = 1'b0;
    set_q(33'd10); exp_q.push_back(32'd10);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_ready1", {63'd0, in_ready}, 64'd1);
    set_q(33'd11); exp_q.push_back(32'd11);
    @(posedge clk); #1;
    check("bp_full", {63'd0, in_ready}, 64'd0);
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    set_q(33'd12);
    @(posedge clk); #1;
    check("bp_stall", {63'd0, in_ready}, 64'd0);
    check("bp_hold", {32'd0, result}, {32'd0, exp_q[0]});
    out_ready = 1'b1;
    #1;
    check("bp_release", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(32'd12);
    check("bp_out0", {32'd0, result}, {32'd0, exp_q.pop_front()});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_valid1", {63'd0, out_valid}, 64'd1);
    check("bp_out1", {32'd0, result}, {32'd0, exp_q.pop_front()});
    @(posedge clk); #1;
    check("bp_valid2", {63'd0, out_valid}, 64'd1);
    check("bp_out2", {32'd0, result}, {32'd0, exp_q.pop_front()});
    @(posedge clk); #1;
    check("bp_empty", {63'd0, out_valid}, 64'd0);
    check("bp_queue", 64'(exp_q.size()), 64'd0);

    // flush with both stages full and a new op offered
    out_ready = 1'b0;
    set_q(33'd20); in_valid = 1'b1;
    @(posedge clk); #1;
    set_q(33'd21);
    @(posedge clk); #1;
    check("fl_full", {63'd0, out_valid}, 64'd1);
    set_q(33'd22); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_outvalid", {63'd0, out_valid}, 64'd0);
    check("fl_inready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("fl_not_taken", {63'd0, out_valid}, 64'd0);

    // reset mid-stream
    out_ready = 1'b0;
    set_q(33'd30); in_valid = 1'b1;
    @(posedge clk); #1;
    set_q(33'd31);
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("mr_outvalid", {63'd0, out_valid}, 64'd0);
    check("mr_inready", {63'd0, in_ready}, 64'd1);
    check("mr_result", {32'd0, result}, 64'd0);
    check("mr_sticky", {63'd0, sticky}, 64'd0);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_no_result", {63'd0, out_valid}, 64'd0);
    set_op(36'd2, 36'd0, 36'd2, 33'd3, 33'd2, 32'd0, 1'b0, 1'b0, 1'b0, 3'b000, 6'd0);
    run32("post_rst", 32'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdivsqrt_intpostproc_pipe.md
# fdivsqrt_intpostproc_pipe

Two-stage, handshake-driven integer postprocessor for the divide/square-root unit. It takes the final carry-save residual and the quotient candidates (U, U-1) from the digit-recurrence iteration. It then performs:
- sticky and negative-residual correction,
- remainder fix-up and normalization shift,
- sign correction and special-case substitution,
- RV64 W-mode sign extension.

It sits between the fdivsqrt iteration datapath and the integer writeback. Unlike the single-stage M-stage postprocessor, it has valid/ready flow control, a flush, and explicit signed-overflow handling.

## Interface
- XLEN, 64, integer operand width (32 or 64)
- LOGR, 1, log2 of radix (1 = radix 2, 2 = radix 4); the residual is arithmetically shifted right by LOGR
- RW, XLEN+4, residual/working width (derived, not overridable)
- SHW, $clog2(XLEN+4), width of normalization shift (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (reset==0 clears state at the clock edge)
- flush  in  1  synchronous; drops both stages (valids to 0) next edge, has priority over accept
- InValid  in  1  operand bundle valid
- InReady  out  1  stage 1 can accept
- WS, WC  in  RW  carry-save residual, two's complement
- D  in  RW  divisor, aligned to residual
- U, UM  in  XLEN+1  quotient and quotient-minus-one
- A  in  XLEN  original dividend (for BZero/ALTB remainders)
- RemOp, As, Bs, W64, BZero, ALTB, SignedOvf  in  1 each  op/case flags
- NormShift  in  SHW  integer normalization right-shift
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- Result  out  XLEN  final integer quotient/remainder
- Sticky  out  1  residual nonzero (inexact), 0 if special case

## Operation
Stage 1, registered on accept (InValid & InReady):
- Sum = WS + WC, RW bits, wraps mod 2^RW.
- Stored: NegSum = Sum[RW-1], SumZero = (Sum == 0).
- Stored: W = $signed(Sum) >>> LOGR, Wd = W + D (RW bits, wrap).
- Stored: Q = NegSum ? UM : U, zero-extended to RW.
- All flags, A and NormShift are registered alongside.

Stage 2, registered when stage 1 advances:
- Rem = NegSum ? Wd : W.
- Pre = RemOp ? Rem : Q.
- Shifted = Pre >> NormShift (logical).
- Neg = As ^ (Bs & ~RemOp); Val = Neg ? -Shifted : Shifted, low XLEN bits.
- Case priority:
  - BZero: Result = RemOp ? A : all-ones.
  - else ALTB: Result = RemOp ? A : 0.
  - else SignedOvf: Result = RemOp ? 0 : A.
  - else Val.
- If XLEN==64 and W64: Result = sign-extend(Result[31:0]).
- Sticky = ~SumZero & ~(BZero | ALTB | SignedOvf).

Flow control:
- s1Adv = S1Valid & (~S2Valid | OutReady).
- InReady = ~S1Valid | s1Adv.
- Combinational from state and OutReady only, never from InValid.
- Stage 2 loads on s1Adv and clears its valid on (OutValid & OutReady & ~s1Adv).
- Stage 1 loads on accept and clears on (s1Adv & ~accept).
- Stage 1 and stage 2 updates are simultaneous and independent when both occur in one cycle (full throughput, one result/cycle).
- Result and Sticky are held stable while OutValid & ~OutReady.

## Timing
- Reset (reset==0 at edge): S1Valid=0, S2Valid=0, OutValid=0, InReady=1 after edge, Result=0, Sticky=0. Data registers other than outputs need not reset.
- Reset during operation discards in-flight ops; no result is produced for them.
- Latency: accept at edge N gives OutValid=1 after edge N+1 (2 cycles) if unstalled.
- Throughput: 1 op/cycle with OutReady=1.
- Capacity: 2 ops. With OutReady=0, the third op sees InReady=0.
- flush with InValid=1 the same cycle: op is not accepted. flush and reset leave Result/Sticky unspecified except under reset, where they are 0.
- Arithmetic is all modular at RW bits. Negation is two's complement, and -0 = 0.

## Test plan
- XLEN=32, LOGR=1: U=3, UM=2, WS=2, WC=0, D=2, RemOp=0, flags 0 -> Result=3, Sticky=1, 2 cycles after accept.
- Same, but WS=-2 (RW ones-pattern), U=4, UM=3; RemOp=0 -> Result=3. RemOp=1 -> Result=1 (Wd=-1+2). Then As=1, RemOp=0 -> Result=0xFFFFFFFD.
- BZero=1, A=0x1234: RemOp=0 -> 0xFFFFFFFF; RemOp=1 -> 0x1234, Sticky=0. ALTB=1 -> 0 / A. SignedOvf=1, A=0x80000000 -> quotient 0x80000000, remainder 0.
- XLEN=64, W64=1, unsigned quotient 0x80000000 -> Result=0xFFFFFFFF80000000. With W64=0 -> 0x0000000080000000.
- Back-pressure: OutReady=0, InValid=1 for 3 cycles -> 2 accepted, InReady=0 on 3rd. Then OutReady=1 -> results drain in order, InReady=1 the same cycle, no loss or duplication.
- Flush and reset: flush with both stages full -> OutValid=0 next cycle, InReady=1. reset=0 mid-stream -> all outputs 0. First op after release returns the correct value 2 cycles later.
